// File: rtl/mul_shift_unit_if.sv
// Handshake and operand bus between the processor controller and the
// multi-cycle multiply/shift unit.
interface mul_shift_unit_if;
  logic       start;
  logic [2:0] opcode;
  logic [7:0] data1;
  logic [7:0] data2;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       error;

  // Controller side: issues operations and watches for completion.
  modport master (
    output start, opcode, data1, data2,
    input  busy, done, result, error
  );

  // Arithmetic unit side.
  modport slave (
    input  start, opcode, data1, data2,
    output busy, done, result, error
  );
endinterface

// File: rtl/mul_shift_unit.sv
// Multi-cycle 8-bit multiply (shift-and-add) and shift/rotate unit.
// One bit of work per clock in RUN; result is presented with a one-cycle
// DONE pulse and then held until the next completed operation.
module mul_shift_unit (
  input  logic              clk,
  input  logic              reset,   // asynchronous, active-low
  mul_shift_unit_if.slave   bus
);

  localparam logic [2:0] OP_MUL = 3'b000;
  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_SRL = 3'b010;
  localparam logic [2:0] OP_SRA = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DONE_ST = 2'd2
  } state_t;

  state_t     state_reg;
  logic [7:0] a_reg;
  logic [7:0] b_reg;
  logic [7:0] p_reg;
  logic [2:0] op_reg;
  logic [3:0] count_reg;
  logic [7:0] result_reg;
  logic       error_reg;

  logic [3:0] n_load;
  logic       op_valid;
  logic [7:0] a_step;
  logic [7:0] b_step;
  logic [7:0] p_step;

  // Step count for the operation being offered on the bus; the full 8 bits
  // of the shift amount take part before clamping or wrapping.
  always_comb begin
    n_load   = 4'd0;
    op_valid = 1'b1;
    case (bus.opcode)
      OP_MUL:                 n_load = 4'd8;
      OP_SLL, OP_SRL, OP_SRA: n_load = (bus.data2 >= 8'd8) ? 4'd8 : bus.data2[3:0];
      OP_ROR:                 n_load = {1'b0, bus.data2[2:0]};
      default: begin
        n_load   = 4'd0;
        op_valid = 1'b0;
      end
    endcase
  end

  // Next values of the working registers for one RUN step.
  always_comb begin
    a_step = a_reg;
    b_step = b_reg;
    p_step = p_reg;
    case (op_reg)
      OP_MUL: begin
        p_step = b_reg[0] ? (p_reg + a_reg) : p_reg;
        a_step = {a_reg[6:0], 1'b0};
        b_step = {1'b0, b_reg[7:1]};
      end
      OP_SLL:  a_step = {a_reg[6:0], 1'b0};
      OP_SRL:  a_step = {1'b0, a_reg[7:1]};
      OP_SRA:  a_step = {a_reg[7], a_reg[7:1]};
      OP_ROR:  a_step = {a_reg[0], a_reg[7:1]};
      default: a_step = a_reg;
    endcase
  end

  // Control FSM and datapath registers; RESULT/ERROR load on entry to DONE_ST.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      a_reg      <= 8'h00;
      b_reg      <= 8'h00;
      p_reg      <= 8'h00;
      op_reg     <= 3'b000;
      count_reg  <= 4'd0;
      result_reg <= 8'h00;
      error_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            a_reg     <= bus.data1;
            b_reg     <= bus.data2;
            op_reg    <= bus.opcode;
            p_reg     <= 8'h00;
            count_reg <= n_load;
            if (n_load != 4'd0) begin
              state_reg <= RUN;
            end else begin
              // Zero-length shift or invalid opcode: finish without RUN.
              state_reg  <= DONE_ST;
              result_reg <= op_valid ? bus.data1 : 8'h00;
              error_reg  <= ~op_valid;
            end
          end
        end
        RUN: begin
          a_reg     <= a_step;
          b_reg     <= b_step;
          p_reg     <= p_step;
          count_reg <= count_reg - 4'd1;
          if (count_reg == 4'd1) begin
            state_reg  <= DONE_ST;
            result_reg <= (op_reg == OP_MUL) ? p_step : a_step;
            error_reg  <= 1'b0;
          end
        end
        DONE_ST: begin
          state_reg <= IDLE;
          error_reg <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.busy   = (state_reg == RUN);
  assign bus.done   = (state_reg == DONE_ST);
  assign bus.result = result_reg;
  assign bus.error  = error_reg;

endmodule

// File: tb/tb_mul_shift_unit.sv
// Directed testbench for mul_shift_unit: hand-computed vectors, checked with
// immediate assertions, sampled on the falling clock edge.
module tb_mul_shift_unit;

  logic clk;
  logic reset;
  int   n_total;
  int   n_fail;

  mul_shift_unit_if bus ();

  mul_shift_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case anything stalls the sequence.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operation (called on a falling edge), count BUSY cycles,
  // then check the DONE cycle and the following idle cycle.
  task automatic run_op(input string tag, input logic [2:0] opc, input logic [7:0] d1,
                        input logic [7:0] d2, input int exp_n, input logic [7:0] exp_res,
                        input logic exp_err);
    int cnt;
    cnt = 0;
    bus.start = 1'b1; bus.opcode = opc; bus.data1 = d1; bus.data2 = d2;
    @(posedge clk);
    @(negedge clk);
    // Scramble inputs after acceptance; they must not matter.
    bus.start = 1'b0; bus.opcode = ~opc; bus.data1 = ~d1; bus.data2 = ~d2;
    while (bus.busy === 1'b1 && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, cnt, exp_n);
    check({tag, "_done"}, bus.done, 1'b1);
    check({tag, "_result"}, bus.result, exp_res);
    check({tag, "_error"}, bus.error, exp_err);
    @(negedge clk);
    check({tag, "_done_drop"}, {bus.busy, bus.done, bus.error}, 3'b000);
    check({tag, "_result_hold"}, bus.result, exp_res);
    $display("op %s opcode=%b a=%h b=%h busy_cycles=%0d result=%h error=%b",
             tag, opc, d1, d2, cnt, bus.result, exp_err);
  endtask

  initial begin
    int cnt;
    n_total = 0;
    n_fail  = 0;
    reset = 1'b0;
    bus.start = 1'b0; bus.opcode = 3'b000; bus.data1 = 8'h00; bus.data2 = 8'h00;

    @(negedge clk);
    @(negedge clk);
    check("reset_state", {bus.busy, bus.done, bus.error, bus.result}, 11'h000);
    reset = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {bus.busy, bus.done, bus.error, bus.result}, 11'h000);

    run_op("mul_7x6",     3'b000, 8'd7,  8'd6,   8, 8'd42,  1'b0);
    run_op("mul_16x20",   3'b000, 8'd16, 8'd20,  8, 8'h40,  1'b0);
    run_op("mul_ffxff",   3'b000, 8'hFF, 8'hFF,  8, 8'h01,  1'b0);
    run_op("sra_90_2",    3'b011, 8'h90, 8'd2,   2, 8'hE4,  1'b0);
    run_op("srl_80_7",    3'b010, 8'h80, 8'd7,   7, 8'h01,  1'b0);
    run_op("ror_81_9",    3'b100, 8'h81, 8'd9,   1, 8'hC0,  1'b0);
    run_op("ror_3c_8",    3'b100, 8'h3C, 8'd8,   0, 8'h3C,  1'b0);
    run_op("sll_5a_0",    3'b001, 8'h5A, 8'd0,   0, 8'h5A,  1'b0);
    run_op("sll_ff_200",  3'b001, 8'hFF, 8'd200, 8, 8'h00,  1'b0);
    run_op("invalid_111", 3'b111, 8'h55, 8'h03,  0, 8'h00,  1'b1);

    // START pulsed during RUN must be ignored and not queued.
    cnt = 0;
    bus.start = 1'b1; bus.opcode = 3'b000; bus.data1 = 8'd2; bus.data2 = 8'd3;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    while (bus.busy === 1'b1 && cnt < 20) begin
      if (cnt == 3) begin
        bus.start = 1'b1; bus.opcode = 3'b001; bus.data1 = 8'hFF; bus.data2 = 8'd0;
      end else begin
        bus.start = 1'b0;
      end
      cnt++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("start_in_run_cycles", cnt, 8);
    check("start_in_run_result", {bus.done, bus.result}, {1'b1, 8'd6});
    @(negedge clk);
    check("start_in_run_not_queued", {bus.busy, bus.done}, 2'b00);
    @(negedge clk);
    check("start_in_run_still_idle", {bus.busy, bus.done, bus.result}, {2'b00, 8'd6});
    $display("op start_in_run busy_cycles=%0d result=%h", cnt, bus.result);

    // Asynchronous reset in the middle of a multiply.
    bus.start = 1'b1; bus.opcode = 3'b000; bus.data1 = 8'd5; bus.data2 = 8'd5;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_mul_busy", bus.busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("async_reset_immediate", {bus.busy, bus.done, bus.error, bus.result}, 11'h000);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("after_reset_idle", {bus.busy, bus.done, bus.result}, 10'h000);
    $display("op mid_mul_reset result=%h busy=%b", bus.result, bus.busy);

    run_op("mul_3x3", 3'b000, 8'd3, 8'd3, 8, 8'd9, 1'b0);

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
